// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port data memory between two requesters. Port A is the CPU
// load/store unit. It gets single-beat accesses and fixed priority. Port B is
// the loader/debug port. It can issue bursts of consecutive addresses that hold
// the memory until the last beat.
//
// A starvation counter stops port A from locking out port B. After
// STARVE_LIMIT consecutive A grants while B waits, B wins the next contested
// IDLE cycle.
//
// Ports
//   clk                        clock, all state changes on the rising edge
//   rst_n                      synchronous reset, ACTIVE-HIGH despite the name
//   a_req/a_we/a_addr/a_wdata  port A single-beat request
//   a_gnt                      port A access performed this cycle
//   a_rvalid/a_rdata           port A read return, one cycle after the grant
//   b_req/b_we/b_addr/b_wdata  port B request (wdata is sampled every beat)
//   b_len                      port B burst length minus 1
//   b_gnt                      port B beat performed this cycle
//   b_rvalid/b_rdata           port B read return, one cycle after each beat
//   b_busy                     high from beat 1 through the last beat of a burst
//   mem_write_en/mem_addr/mem_data_in   memory control
//   mem_data_out               combinational memory read data
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [3:0]        b_len,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_busy,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic {
      IDLE,
      B_BURST
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        beat_q, beat_d;
   logic [3:0]        len_q, len_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic [CNT_W-1:0]  starve_q, starve_d;

   logic              a_rvalid_q, b_rvalid_q;
   logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

   // Asserted on a granted read beat. The port's rdata register captures
   // mem_data_out at the end of that cycle.
   logic              a_rd_cap, b_rd_cap;
   logic              a_win;

   // Next-state, grant and memory-control logic.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      len_d        = len_q;
      base_d       = base_q;
      we_d         = we_q;
      starve_d     = starve_q;
      a_gnt        = 1'b0;
      b_gnt        = 1'b0;
      b_busy       = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = a_addr;
      mem_data_in  = a_wdata;
      a_rd_cap     = 1'b0;
      b_rd_cap     = 1'b0;

      // A wins every contested cycle except when B has waited out the limit.
      a_win = a_req && !(b_req && (starve_q == LIMIT));

      // Reset gates every grant combinationally. This ensures that an aborted
      // burst writes nothing in the reset cycle.
      if (!rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (a_win) begin
                  a_gnt        = 1'b1;
                  mem_write_en = a_we;
                  a_rd_cap     = !a_we;
                  if (b_req && (starve_q != LIMIT)) begin
                     starve_d = starve_q + 1'b1;
                  end
               end else if (b_req) begin
                  // Beat 0 goes straight through. Later beats use latched
                  // control.
                  b_gnt        = 1'b1;
                  mem_addr     = b_addr;
                  mem_data_in  = b_wdata;
                  mem_write_en = b_we;
                  b_rd_cap     = !b_we;
                  starve_d     = '0;
                  if (b_len != 4'd0) begin
                     base_d  = b_addr;
                     we_d    = b_we;
                     len_d   = b_len;
                     beat_d  = 4'd1;
                     state_d = B_BURST;
                  end
               end
            end
            B_BURST: begin
               b_gnt        = 1'b1;
               b_busy       = 1'b1;
               // This address arithmetic wraps naturally at 2^ADDR_W.
               mem_addr     = base_q + ADDR_W'(beat_q);
               mem_data_in  = b_wdata;
               mem_write_en = we_q;
               b_rd_cap     = !we_q;
               if (beat_q == len_q) begin
                  beat_d  = 4'd0;
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase

         // B is no longer waiting, so any accumulated A streak no longer counts.
         if (!b_req) begin
            starve_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= IDLE;
         beat_q     <= 4'd0;
         len_q      <= 4'd0;
         base_q     <= '0;
         we_q       <= 1'b0;
         starve_q   <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         len_q      <= len_d;
         base_q     <= base_d;
         we_q       <= we_d;
         starve_q   <= starve_d;
         a_rvalid_q <= a_rd_cap;
         b_rvalid_q <= b_rd_cap;
         if (a_rd_cap) begin
            a_rdata_q <= mem_data_out;
         end
         if (b_rd_cap) begin
            b_rdata_q <= mem_data_out;
         end
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rvalid = b_rvalid_q;
   assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed testbench for data_mem_arbiter with ADDR_W=6, DATA_W=16 and
// STARVE_LIMIT=4. The bench provides a behavioural 64-word memory with a
// synchronous write and a combinational read.
//
// Inputs are driven on the falling edge. Grants and memory control are checked
// 1 ns later. Registered read returns are checked 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int AW = 6;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_req, a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_gnt, a_rvalid;
   logic [DW-1:0] a_rdata;
   logic          b_req, b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic [3:0]    b_len;
   logic          b_gnt, b_rvalid, b_busy;
   logic [DW-1:0] b_rdata;
   logic          mem_write_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] tb_mem [0:63];
   logic          mem_clr;
   logic [AW-1:0] burst_addrs [0:3];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 64; k++) tb_mem[k] <= '0;
      end else if (mem_write_en) begin
         tb_mem[mem_addr] <= mem_data_in;
      end
   end
   assign mem_data_out = tb_mem[mem_addr];

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_len(b_len), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .b_busy(b_busy), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   task automatic idle_inputs();
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_len = 4'd0;
   endtask

   // Advance from the current falling edge to the sampling point 1 ns after
   // the next rising edge.
   task automatic to_post_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; mem_clr = 1'b1;
      idle_inputs();
      a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b1; b_len = 4'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL reset_a_gnt: got %0b expected 0", a_gnt); end
      checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL reset_b_gnt: got %0b expected 0", b_gnt); end
      checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", mem_write_en); end
      checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got a=%0b b=%0b expected 0/0", a_rvalid, b_rvalid); end
      checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got a=%h b=%h expected 0000/0000", a_rdata, b_rdata); end
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", b_busy); end
      $display("reset: outputs sampled with rst_n=1");
      @(negedge clk);
      rst_n = 1'b0; mem_clr = 1'b0;
      idle_inputs();
   endtask

   task automatic test_a_only();
      a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 16'h1234;
      #1;
      checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL a_wr_gnt: got a=%0b b=%0b expected 1/0", a_gnt, b_gnt); end
      checks++; if (mem_write_en !== 1'b1 || mem_addr !== 6'd5 || mem_data_in !== 16'h1234) begin errors++; $display("FAIL a_wr_mem: got we=%0b addr=%0d data=%h expected 1/5/1234", mem_write_en, mem_addr, mem_data_in); end
      to_post_edge();
      checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL a_wr_no_rvalid: got %0b expected 0", a_rvalid); end
      $display("a_only: write addr 5 data 1234");
      @(negedge clk);
      a_we = 1'b0; a_wdata = 16'h0;
      #1;
      checks++; if (a_gnt !== 1'b1 || mem_write_en !== 1'b0) begin errors++; $display("FAIL a_rd_gnt: got gnt=%0b we=%0b expected 1/0", a_gnt, mem_write_en); end
      to_post_edge();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin errors++; $display("FAIL a_rd_data: got rvalid=%0b rdata=%h expected 1/1234", a_rvalid, a_rdata); end
      $display("a_only: read addr 5 returned %h", a_rdata);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL idle_no_gnt: got a=%0b b=%0b we=%0b expected 0/0/0", a_gnt, b_gnt, mem_write_en); end
      to_post_edge();
      checks++; if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin errors++; $display("FAIL a_rdata_hold: got rvalid=%0b rdata=%h expected 0/1234", a_rvalid, a_rdata); end
      @(negedge clk);
   endtask

   // The expected order for two continuous requesters is A,A,A,A,B, repeated.
   task automatic test_starvation();
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5;
      b_req = 1'b1; b_we = 1'b0; b_addr = 6'd5; b_len = 4'd0;
      for (int i = 0; i < 10; i++) begin
         logic exp_b;
         exp_b = (i % 5 == 4);
         #1;
         checks++; if (a_gnt !== !exp_b || b_gnt !== exp_b) begin errors++; $display("FAIL starve_order[%0d]: got a=%0b b=%0b expected a=%0b b=%0b", i, a_gnt, b_gnt, !exp_b, exp_b); end
         to_post_edge();
         checks++; if (b_rvalid !== exp_b) begin errors++; $display("FAIL starve_b_rvalid[%0d]: got %0b expected %0b", i, b_rvalid, exp_b); end
         if (exp_b) begin
            checks++; if (b_rdata !== 16'h1234) begin errors++; $display("FAIL starve_b_rdata[%0d]: got %h expected 1234", i, b_rdata); end
         end
         $display("starve: cycle %0d a_gnt=%0b b_gnt=%0b", i, !exp_b, exp_b);
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_burst_write();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            b_req = 1'b1; b_we = 1'b1; b_addr = 6'd62; b_len = 4'd3; a_req = 1'b0;
         end else begin
            // During the burst, B's control inputs must be ignored, and A must
            // not be granted.
            b_req = 1'b0; b_we = 1'b0; b_addr = 6'd7; b_len = 4'd0;
            a_req = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 16'hDEAD;
         end
         b_wdata = 16'h00A0 + 16'(i);
         #1;
         checks++; if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin errors++; $display("FAIL bw_gnt[%0d]: got a=%0b b=%0b expected 0/1", i, a_gnt, b_gnt); end
         checks++; if (mem_addr !== burst_addrs[i] || mem_write_en !== 1'b1 || mem_data_in !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL bw_mem[%0d]: got addr=%0d we=%0b data=%h expected %0d/1/%h", i, mem_addr, mem_write_en, mem_data_in, burst_addrs[i], 16'h00A0 + 16'(i)); end
         checks++; if (b_busy !== (i > 0)) begin errors++; $display("FAIL bw_busy[%0d]: got %0b expected %0b", i, b_busy, (i > 0)); end
         $display("burst_write: beat %0d addr %0d data %h", i, mem_addr, mem_data_in);
         to_post_edge();
         @(negedge clk);
      end
      b_req = 1'b0; b_wdata = '0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd62;
      #1;
      checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL bw_after_a_gnt: got a=%0b b=%0b busy=%0b expected 1/0/0", a_gnt, b_gnt, b_busy); end
      to_post_edge();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h00A0) begin errors++; $display("FAIL bw_after_a_rdata: got rvalid=%0b rdata=%h expected 1/00a0", a_rvalid, a_rdata); end
      @(negedge clk);
      idle_inputs();
      checks++; if (tb_mem[62] !== 16'h00A0 || tb_mem[63] !== 16'h00A1 || tb_mem[0] !== 16'h00A2 || tb_mem[1] !== 16'h00A3) begin errors++; $display("FAIL bw_mem_contents: got %h %h %h %h expected 00a0 00a1 00a2 00a3", tb_mem[62], tb_mem[63], tb_mem[0], tb_mem[1]); end
      checks++; if (tb_mem[10] !== 16'h0) begin errors++; $display("FAIL bw_no_a_write: got %h expected 0000", tb_mem[10]); end
   endtask

   task automatic test_burst_read();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = 6'd62; b_len = 4'd3;
         end else begin
            b_req = 1'b0; b_addr = 6'd0; b_len = 4'd0;
         end
         #1;
         checks++; if (b_gnt !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== burst_addrs[i]) begin errors++; $display("FAIL br_beat[%0d]: got gnt=%0b we=%0b addr=%0d expected 1/0/%0d", i, b_gnt, mem_write_en, mem_addr, burst_addrs[i]); end
         to_post_edge();
         checks++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h00A0 + 16'(i)) begin errors++; $display("FAIL br_rdata[%0d]: got rvalid=%0b rdata=%h expected 1/%h", i, b_rvalid, b_rdata, 16'h00A0 + 16'(i)); end
         $display("burst_read: beat %0d returned %h", i, b_rdata);
         @(negedge clk);
      end
      idle_inputs();
      #1;
      checks++; if (b_gnt !== 1'b0) begin errors++; $display("FAIL br_end_gnt: got %0b expected 0", b_gnt); end
      to_post_edge();
      checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL br_end_rvalid: got %0b expected 0", b_rvalid); end
      @(negedge clk);
   endtask

   // This test performs beats 0..2 of a 6-beat write burst, then asserts
   // reset.
   task automatic test_reset_abort();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin
            b_req = 1'b1; b_we = 1'b1; b_addr = 6'd20; b_len = 4'd5;
         end else begin
            b_req = 1'b0;
         end
         b_wdata = 16'h00B0 + 16'(i);
         #1;
         checks++; if (b_gnt !== 1'b1 || mem_addr !== 6'd20 + 6'(i)) begin errors++; $display("FAIL abort_beat[%0d]: got gnt=%0b addr=%0d expected 1/%0d", i, b_gnt, mem_addr, 20 + i); end
         to_post_edge();
         @(negedge clk);
      end
      rst_n = 1'b1; b_wdata = 16'h00B3;
      a_req = 1'b1; a_we = 1'b1; a_addr = 6'd30; a_wdata = 16'hBEEF;
      #1;
      checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL abort_forced: got a=%0b b=%0b we=%0b expected 0/0/0", a_gnt, b_gnt, mem_write_en); end
      to_post_edge();
      checks++; if (b_busy !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin errors++; $display("FAIL abort_reset_state: got busy=%0b arv=%0b brv=%0b ard=%h brd=%h expected 0/0/0/0000/0000", b_busy, a_rvalid, b_rvalid, a_rdata, b_rdata); end
      $display("reset_abort: reset applied after beat 2");
      @(negedge clk);
      rst_n = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd21;
      b_req = 1'b0; b_wdata = 16'h00B4;
      #1;
      checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL abort_a_after: got a=%0b b=%0b expected 1/0", a_gnt, b_gnt); end
      to_post_edge();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'h00B1) begin errors++; $display("FAIL abort_a_rdata: got rvalid=%0b rdata=%h expected 1/00b1", a_rvalid, a_rdata); end
      @(negedge clk);
      idle_inputs();
      b_wdata = 16'h00B5;
      repeat (3) @(negedge clk);
      checks++; if (tb_mem[20] !== 16'h00B0 || tb_mem[21] !== 16'h00B1 || tb_mem[22] !== 16'h00B2) begin errors++; $display("FAIL abort_written: got %h %h %h expected 00b0 00b1 00b2", tb_mem[20], tb_mem[21], tb_mem[22]); end
      checks++; if (tb_mem[23] !== 16'h0 || tb_mem[24] !== 16'h0 || tb_mem[25] !== 16'h0 || tb_mem[30] !== 16'h0) begin errors++; $display("FAIL abort_unwritten: got %h %h %h %h expected 0000 x4", tb_mem[23], tb_mem[24], tb_mem[25], tb_mem[30]); end
      b_wdata = '0;
   endtask

   // In this test, three A grants are made against a waiting B, and then b_req
   // drops for one cycle. The counter must restart, so A gets four more grants
   // before B.
   task automatic test_starve_clear();
      logic [8:0] b_pattern;
      logic [8:0] b_req_pattern;
      b_pattern     = 9'b100000000;
      b_req_pattern = 9'b111110111;
      a_req = 1'b1; a_we = 1'b0; a_addr = 6'd0; b_we = 1'b0; b_addr = 6'd1; b_len = 4'd0;
      for (int i = 0; i < 9; i++) begin
         b_req = b_req_pattern[i];
         #1;
         checks++; if (a_gnt !== !b_pattern[i] || b_gnt !== b_pattern[i]) begin errors++; $display("FAIL starve_clear[%0d]: got a=%0b b=%0b expected a=%0b b=%0b", i, a_gnt, b_gnt, !b_pattern[i], b_pattern[i]); end
         $display("starve_clear: cycle %0d b_req=%0b a_gnt=%0b b_gnt=%0b", i, b_req, a_gnt, b_gnt);
         to_post_edge();
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      burst_addrs[0] = 6'd62; burst_addrs[1] = 6'd63;
      burst_addrs[2] = 6'd0;  burst_addrs[3] = 6'd1;
      test_reset();
      test_a_only();
      test_starvation();
      test_burst_write();
      test_burst_read();
      test_reset_abort();
      test_starve_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-port 16-bit data memory (64 words, or 512 words for the large variant). It shares the memory between the CPU load/store unit (port A) and the loader/debug port (port B). Port A has fixed priority, limited by a starvation counter. Port B may issue bursts of consecutive accesses that hold the memory until they finish. All memory control (write enable, address, write data) passes through this block, and read data returns to each requester with a registered one-cycle latency.

## Interface
- ADDR_W, 6, memory address width (9 for the 512-word variant)
- DATA_W, 16, data width
- STARVE_LIMIT, 4, consecutive port-A grants while port B waits before B is forced to win
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous and active-high despite the name
- a_req  in  1  port A access request, single beat
- a_we  in  1  port A write (1) or read (0)
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  port A access performed this cycle
- a_rvalid  out  1  port A read data valid, one cycle after a read grant
- a_rdata  out  DATA_W  port A read data
- b_req, b_we, b_addr, b_wdata  in  1/1/ADDR_W/DATA_W  port B equivalents of the port A inputs
- b_len  in  4  port B burst length minus 1 (0 gives a single beat, 15 gives 16 beats)
- b_gnt  out  1  port B beat performed this cycle
- b_rvalid, b_rdata  out  1/DATA_W  port B read return
- b_busy  out  1  port B burst in progress (high from beat 1 through the last beat)
- mem_write_en  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory combinational read data

## Operation
- States: IDLE and B_BURST. Port A accesses are always single-cycle and are performed from IDLE.
- IDLE arbitration (combinational):
  - Neither port requesting: no grant.
  - Only A requesting: A granted.
  - Only B requesting: B granted.
  - Both requesting: A granted, unless starve_cnt == STARVE_LIMIT, in which case B is granted.
- A grant: in that cycle a_gnt=1, mem_addr=a_addr, mem_data_in=a_wdata, mem_write_en=a_we.
- B grant in IDLE performs beat 0 in that cycle:
  - b_gnt=1, mem_addr=b_addr, mem_data_in=b_wdata, mem_write_en=b_we.
  - If b_len>0: latch b_addr, b_we and b_len, set beat=1, go to B_BURST.
- B_BURST:
  - Each cycle b_gnt=1 and mem_addr = latched_addr + beat, taken modulo 2^ADDR_W so it wraps from the top address to 0.
  - mem_write_en = latched b_we.
  - mem_data_in = current b_wdata; B must present the next word in each granted cycle.
  - b_req, b_addr, b_we and b_len are ignored during the burst.
  - After the beat where beat == latched_len, return to IDLE. A burst cannot be pre-empted.
- starve_cnt (width sized to hold STARVE_LIMIT):
  - +1 on each A grant while b_req=1, saturating at STARVE_LIMIT.
  - Cleared on any B grant in IDLE, and on any cycle with b_req=0.
- Read return:
  - On a granted read beat, the port's rdata register captures mem_data_out at the clock edge.
  - That port's rvalid is high for the following cycle.
  - rdata holds its value until the next read return.
- Writes produce no rvalid.
- When the memory is idle: mem_write_en=0; mem_addr and mem_data_in hold A's inputs (don't-care).

## Timing
- Grant is combinational from the request in the same cycle; the access happens in the grant cycle.
- Read latency: rvalid and rdata appear 1 cycle after the grant.
- A burst with b_len=L occupies exactly L+1 consecutive cycles with b_gnt=1.
- a_gnt is never high in the same cycle as b_gnt. It is 0 throughout B_BURST.
- After a burst ends, A can be granted in the first IDLE cycle.
- Reset, when rst_n=1 at an edge:
  - state=IDLE, beat=0, starve_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, b_busy=0.
- While rst_n=1, a_gnt, b_gnt and mem_write_en are forced to 0 combinationally.
- Reset during a burst aborts it: no further beats are performed and no rvalid is issued for the aborted burst.

## Test plan
- A only: write addr 5 data 0x1234, then read addr 5 -> a_gnt for 1 cycle each; a_rvalid one cycle after the read grant; a_rdata=0x1234.
- A and B both requesting continuously, STARVE_LIMIT=4 -> grants follow A,A,A,A,B and repeat; no two grants in one cycle.
- B write burst, b_addr=62, b_len=3, ADDR_W=6, data 0xA0..0xA3 -> b_gnt high for 4 cycles; addresses 62,63,0,1; memory holds those values; a_req held high during the burst is not granted until the following cycle.
- B read burst of the same region -> b_rvalid high for 4 consecutive cycles, each one cycle behind its beat; b_rdata sequence 0xA0..0xA3.
- rst_n asserted at beat 2 of a 6-beat write burst -> beats 3..5 are not written; all outputs at reset values; A is granted immediately after reset is released.
- b_req drops for one cycle while starve_cnt=3 -> starve_cnt clears; with both ports requesting again, A receives 4 further grants before B.
